// File: rtl/aes_key_schedule_multi.sv
// Iterative AES-128/192/256 key expander. The cipher key arrives as a word stream,
// one expanded word w[i] is produced per cycle into a word store, and round-key words
// are served through a read port that is registered or combinational.
module aes_key_schedule_multi #(
  parameter int unsigned MAX_NK = 8,
  parameter int unsigned RD_REG = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [1:0]  key_len_i,
  input  logic        key_valid_i,
  input  logic [31:0] cipher_key_i,
  input  logic        rd_en_i,
  input  logic [3:0]  rd_round_i,
  input  logic [1:0]  rd_word_i,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        busy_o,
  output logic        ready_o,
  output logic        err_o
);

  localparam int unsigned Depth = 4 * (MAX_NK + 7);
  localparam int unsigned AW    = $clog2(Depth);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StExpand = 2'd2;
  localparam logic [1:0] StReady  = 2'd3;

  // FIPS-197 S-box, entry 0 in the most-significant byte.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    // Byte x sits at bit 2047-8x, i.e. {~x, 3'b111}.
    sbox = SboxTable[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [1:0]    state_q, state_d;
  logic [3:0]    nk_q, nk_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [2:0]    mod_q, mod_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          err_start_q, err_start_d;

  logic [31:0]   w_q [Depth];

  logic [3:0]    nk_dec;
  logic          len_legal;
  logic [3:0]    nr;
  logic [AW-1:0] last_idx;
  logic          mod_last;
  logic [31:0]   prev_w, back_w, sub_in, sub_out, t_w, new_w;
  logic          we;
  logic [31:0]   wdata;

  // Key-length decode and derived schedule bounds.
  always_comb begin
    nk_dec = 4'd4;
    case (key_len_i)
      2'd1:    nk_dec = 4'd6;
      2'd2:    nk_dec = 4'd8;
      default: nk_dec = 4'd4;
    endcase
    len_legal = (key_len_i != 2'd3) && (32'(nk_dec) <= MAX_NK);
    nr        = nk_q + 4'd6;
    last_idx  = AW'({nk_q, 2'b00} + 6'd27);
    mod_last  = ({1'b0, mod_q} == (nk_q - 4'd1));
  end

  // One expansion step: w[i] = w[i-Nk] ^ t(w[i-1]).
  always_comb begin
    prev_w  = w_q[idx_q - AW'(1)];
    back_w  = w_q[idx_q - AW'(nk_q)];
    sub_in  = (mod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    t_w     = prev_w;
    if (mod_q == 3'd0) begin
      t_w = sub_out ^ {rcon_q, 24'h0};
    end else if (nk_q == 4'd8 && mod_q == 3'd4) begin
      t_w = sub_out;
    end
    new_w = back_w ^ t_w;
  end

  // Control next-state; start overrides everything, including a same-cycle key word.
  always_comb begin
    state_d     = state_q;
    nk_d        = nk_q;
    idx_d       = idx_q;
    mod_d       = mod_q;
    rcon_d      = rcon_q;
    err_start_d = 1'b0;
    we          = 1'b0;
    wdata       = cipher_key_i;
    if (start_i) begin
      idx_d = '0;
      if (len_legal) begin
        state_d = StLoad;
        nk_d    = nk_dec;
      end else begin
        state_d     = StIdle;
        err_start_d = 1'b1;
      end
    end else begin
      case (state_q)
        StLoad: begin
          if (key_valid_i) begin
            we = 1'b1;
            if (idx_q == AW'(nk_q - 4'd1)) begin
              state_d = StExpand;
              idx_d   = AW'(nk_q);
              mod_d   = 3'd0;
              rcon_d  = 8'h01;
            end else begin
              idx_d = idx_q + AW'(1);
            end
          end
        end
        StExpand: begin
          we    = 1'b1;
          wdata = new_w;
          if (idx_q == last_idx) begin
            state_d = StReady;
          end else begin
            idx_d = idx_q + AW'(1);
          end
          mod_d = mod_last ? 3'd0 : mod_q + 3'd1;
          if (mod_q == 3'd0) begin
            rcon_d = xtime(rcon_q);
          end
        end
        default: ;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      nk_q        <= 4'd4;
      idx_q       <= '0;
      mod_q       <= 3'd0;
      rcon_q      <= 8'h01;
      err_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nk_q        <= nk_d;
      idx_q       <= idx_d;
      mod_q       <= mod_d;
      rcon_q      <= rcon_d;
      err_start_q <= err_start_d;
    end
  end

  // Word store; deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we) begin
      w_q[idx_q] <= wdata;
    end
  end

  assign busy_o  = (state_q == StLoad) || (state_q == StExpand);
  assign ready_o = (state_q == StReady);

  logic [5:0]  rd_addr;
  logic        rd_ok;
  logic [31:0] rd_word_val;
  logic        rd_err;

  // Round r word k lives at 4r+k, which is just the concatenation.
  always_comb begin
    rd_addr     = {rd_round_i, rd_word_i};
    rd_ok       = ready_o && (rd_round_i <= nr);
    rd_word_val = rd_ok ? w_q[AW'(rd_addr)] : 32'h0;
  end

  if (RD_REG != 0) begin : g_rd_reg
    logic [31:0] rd_data_q;
    logic        rd_valid_q;
    logic        rd_err_q;

    // Registered read port: one-cycle latency, one read per cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        rd_data_q  <= 32'h0;
        rd_valid_q <= 1'b0;
        rd_err_q   <= 1'b0;
      end else begin
        rd_data_q  <= rd_word_val;
        rd_valid_q <= rd_en_i;
        rd_err_q   <= rd_en_i && !rd_ok;
      end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_err     = rd_err_q;
  end else begin : g_rd_comb
    assign rd_data_o  = rd_en_i ? rd_word_val : 32'h0;
    assign rd_valid_o = rd_en_i;
    assign rd_err     = rd_en_i && !rd_ok;
  end

  assign err_o = err_start_q || rd_err;

endmodule
